// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and constants for the RAM sequencing controller / two-port arbiter.
//   arb_state_e : controller states (IDLE, ISSUE, WAIT, RESP)
//   GNT_CPU/LDR : grant encoding, also the bit index of each requester in the request vector
//   DEF_*       : default RAM geometry and done timeout
package ram_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 9;
    localparam int unsigned DEF_TIMEOUT    = 15;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way alternating arbiter.
//   req[1:0]   in  : request vector, bit GNT_CPU = CPU, bit GNT_LDR = loader
//   last_grant in  : requester granted most recently
//   grant      out : winning requester (only meaningful when any req is set)
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = GNT_CPU;
        unique case (req)
            2'b01:   grant = GNT_CPU;
            2'b10:   grant = GNT_LDR;
            // Contended: whoever did not win last time goes now.
            2'b11:   grant = ~last_grant;
            default: grant = GNT_CPU;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Sequencing controller and CPU/loader arbiter in front of a single-port RAM.
// Latches the winning request, holds RAM strobes from ISSUE through WAIT until ram_done
// or a timeout, then pulses a one-cycle ack to the winner in RESP.
//   clk, reset_n                            : clock, async active-low reset
//   cpu_req/we/addr/wdata                   : CPU request (level, held until cpu_ack)
//   cpu_rdata/ack/err                       : CPU response (rdata held between reads)
//   ldr_req/addr/wdata, ldr_ack             : write-only loader port
//   ram_read/write/enable/address/data_in   : RAM strobes and write path
//   ram_data_out, ram_done                  : RAM read data and completion
//   busy                                    : high whenever not IDLE
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    input  logic                  ldr_req,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic                  ram_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_done,
    output logic                  busy
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    arb_state_e            r_state, w_state_d;
    logic                  r_grant, w_grant_d;
    logic                  r_last_grant, w_last_grant_d;
    logic                  r_we, w_we_d;
    logic                  r_err, w_err_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
    logic [DATA_WIDTH-1:0] r_cpu_rdata, w_cpu_rdata_d;
    logic [7:0]            r_cnt, w_cnt_d;
    logic [7:0]            w_cnt_inc;
    logic                  w_arb_grant;

    rr_arb2 u_rr_arb2 (
        .req        ({ldr_req, cpu_req}),
        .last_grant (r_last_grant),
        .grant      (w_arb_grant)
    );

    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_d      = r_state;
        w_grant_d      = r_grant;
        w_last_grant_d = r_last_grant;
        w_we_d         = r_we;
        w_err_d        = r_err;
        w_addr_d       = r_addr;
        w_wdata_d      = r_wdata;
        w_cpu_rdata_d  = r_cpu_rdata;
        w_cnt_d        = r_cnt;

        unique case (r_state)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    w_grant_d = w_arb_grant;
                    if (w_arb_grant == GNT_LDR) begin
                        w_addr_d  = ldr_addr;
                        w_wdata_d = ldr_wdata;
                        w_we_d    = 1'b1;
                    end else begin
                        w_addr_d  = cpu_addr;
                        w_wdata_d = cpu_wdata;
                        w_we_d    = cpu_we;
                    end
                    w_state_d = ISSUE;
                end
            end
            ISSUE: begin
                // ram_done is deliberately not looked at here.
                w_cnt_d   = '0;
                w_state_d = WAIT;
            end
            WAIT: begin
                w_cnt_d = w_cnt_inc;
                // Done is checked first so it beats a timeout landing in the same cycle.
                if (ram_done) begin
                    w_err_d = 1'b0;
                    if ((r_grant == GNT_CPU) && !r_we) begin
                        w_cpu_rdata_d = ram_data_out;
                    end
                    w_state_d = RESP;
                end else if (w_cnt_inc == TIMEOUT_CNT) begin
                    w_err_d   = 1'b1;
                    w_state_d = RESP;
                end
            end
            RESP: begin
                w_last_grant_d = r_grant;
                w_state_d      = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= GNT_CPU;
            r_last_grant <= GNT_CPU;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_d;
            r_grant      <= w_grant_d;
            r_last_grant <= w_last_grant_d;
            r_we         <= w_we_d;
            r_err        <= w_err_d;
            r_addr       <= w_addr_d;
            r_wdata      <= w_wdata_d;
            r_cpu_rdata  <= w_cpu_rdata_d;
            r_cnt        <= w_cnt_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign ram_enable  = (r_state == ISSUE) || (r_state == WAIT);
    assign ram_write   = ram_enable && r_we;
    assign ram_read    = ram_enable && !r_we;
    assign ram_address = r_addr;
    assign ram_data_in = r_wdata;

    assign cpu_ack   = (r_state == RESP) && (r_grant == GNT_CPU);
    assign ldr_ack   = (r_state == RESP) && (r_grant == GNT_LDR);
    assign cpu_err   = cpu_ack && r_err;
    assign cpu_rdata = r_cpu_rdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Scoreboarded bench: a request-level model decides grant order, RAM contents, errors and
// returned data; a monitor compares every RAM access and ack against the queued expectations.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int TO = 15;

    typedef struct {
        logic        who;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          delay;     // WAIT cycle in which the RAM answers; 0 = never
    } txn_t;

    typedef struct {
        logic        who;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          en_cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [8:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic        ldr_req = 1'b0;
    logic [8:0]  ldr_addr = '0;
    logic [31:0] ldr_wdata = '0;
    logic        ldr_ack;
    logic        ram_read, ram_write, ram_enable;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out;
    logic        ram_done;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    txn_t cpu_q[$];
    txn_t ldr_q[$];
    exp_t exp_q[$];
    int   delay_q[$];

    bit [31:0] ram_mem [512];
    bit [31:0] m_mem [512];
    logic        m_last = GNT_CPU;
    logic [31:0] m_rdata = '0;
    int   en_cnt = 0;
    int   cur_delay = 0;
    logic spur = 1'b0;
    logic solo = 1'b0;
    logic ignore_access = 1'b0;

    ram_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (9),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .cpu_err      (cpu_err),
        .ldr_req      (ldr_req),
        .ldr_addr     (ldr_addr),
        .ldr_wdata    (ldr_wdata),
        .ldr_ack      (ldr_ack),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ram_enable   (ram_enable),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .ram_done     (ram_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic bit is_err(int d);
        return (d == 0) || (d > TO);
    endfunction

    function automatic int eff_cycles(int d);
        return is_err(d) ? TO : d;
    endfunction

    function automatic txn_t mk(logic who, logic we, int addr, logic [31:0] wdata, int delay);
        txn_t t;
        t.who   = who;
        t.we    = we;
        t.addr  = 9'(addr);
        t.wdata = wdata;
        t.delay = delay;
        return t;
    endfunction

    // RAM stand-in: answers in the WAIT cycle given by the current access's delay.
    assign ram_data_out = ram_mem[ram_address];
    assign ram_done = ram_enable && ((en_cnt == 0 && spur) || (en_cnt != 0 && en_cnt == cur_delay));

    initial begin : ram_seq
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                en_cnt <= 0;
            end else begin
                en_cnt <= ram_enable ? en_cnt + 1 : 0;
                if (ram_enable && ram_write && ram_done && en_cnt != 0) begin
                    ram_mem[ram_address] <= ram_data_in;
                end
            end
        end
    end

    initial begin : ram_delay
        forever begin
            @(negedge clk);
            if (reset_n && ram_enable && en_cnt == 0) begin
                if (delay_q.size() == 0) chk("delay_available", 0, 1);
                else cur_delay = delay_q.pop_front();
            end
        end
    end

    // Reference model: serve pending requests in alternating order when both are waiting.
    task automatic plan();
        int   i = 0;
        int   j = 0;
        logic win;
        txn_t t;
        exp_t e;
        while (i < cpu_q.size() || j < ldr_q.size()) begin
            if (i < cpu_q.size() && j < ldr_q.size()) win = ~m_last;
            else win = (j < ldr_q.size()) ? GNT_LDR : GNT_CPU;
            if (win == GNT_LDR) begin
                t = ldr_q[j];
                j++;
            end else begin
                t = cpu_q[i];
                i++;
            end
            m_last = win;
            e.who   = win;
            e.we    = t.we;
            e.addr  = t.addr;
            e.wdata = t.wdata;
            e.err   = is_err(t.delay);
            if (!e.err && t.we) m_mem[t.addr] = t.wdata;
            if (!e.err && !t.we && win == GNT_CPU) m_rdata = m_mem[t.addr];
            e.rdata     = m_rdata;
            e.en_cycles = eff_cycles(t.delay) + 1;
            exp_q.push_back(e);
            delay_q.push_back(t.delay);
        end
    endtask

    task automatic drive_cpu();
        foreach (cpu_q[n]) begin
            int start;
            bit got;
            cpu_addr  = cpu_q[n].addr;
            cpu_we    = cpu_q[n].we;
            cpu_wdata = cpu_q[n].wdata;
            cpu_req   = 1'b1;
            start = cyc;
            got   = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                @(negedge clk);
                if (cpu_ack) begin
                    got = 1'b1;
                end else if (solo && k == 1) begin
                    // Already latched: these changes must not reach the RAM.
                    cpu_addr  = 9'($urandom_range(0, 511));
                    cpu_wdata = $urandom;
                    cpu_we    = ~cpu_we;
                end
            end
            if (!got) chk("cpu_ack_seen", 0, 1);
            else if (solo) chk("cpu_latency", cyc - start, eff_cycles(cpu_q[n].delay) + 2);
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
    endtask

    task automatic drive_ldr();
        foreach (ldr_q[n]) begin
            int start;
            bit got;
            ldr_addr  = ldr_q[n].addr;
            ldr_wdata = ldr_q[n].wdata;
            ldr_req   = 1'b1;
            start = cyc;
            got   = 1'b0;
            for (int k = 0; k < 400 && !got; k++) begin
                @(negedge clk);
                if (ldr_ack) begin
                    got = 1'b1;
                end else if (solo && k == 1) begin
                    ldr_addr  = 9'($urandom_range(0, 511));
                    ldr_wdata = $urandom;
                end
            end
            if (!got) chk("ldr_ack_seen", 0, 1);
            else if (solo) chk("ldr_latency", cyc - start, eff_cycles(ldr_q[n].delay) + 2);
            @(posedge clk);
            #1;
        end
        ldr_req = 1'b0;
    endtask

    task automatic run_round();
        solo = (cpu_q.size() == 0) || (ldr_q.size() == 0);
        plan();
        fork
            drive_cpu();
            drive_ldr();
        join
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        delay_q.delete();
        cpu_q.delete();
        ldr_q.delete();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_delay();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return TO;
            2:       return TO + 1;
            3:       return TO - 1;
            default: return int'($urandom_range(1, 5));
        endcase
    endfunction

    function automatic int rnd_addr();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 511;
            default: return int'($urandom_range(0, 511));
        endcase
    endfunction

    initial begin : monitor
        int   mon_en = 0;
        bit   chk_idle = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_en   = 0;
                chk_idle = 1'b0;
            end else begin
                chk("ack_exclusive", 32'(cpu_ack && ldr_ack), 0);
                if (ram_enable && !ignore_access) begin
                    mon_en++;
                    if (exp_q.size() == 0) begin
                        chk("access_expected", 0, 1);
                    end else begin
                        e = exp_q[0];
                        chk("ram_address", 32'(ram_address), 32'(e.addr));
                        chk("ram_write", 32'(ram_write), 32'(e.we));
                        chk("ram_read", 32'(ram_read), 32'(!e.we));
                        if (e.we) chk("ram_data_in", ram_data_in, e.wdata);
                        chk("busy_active", 32'(busy), 1);
                    end
                end
                if (cpu_ack || ldr_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("ack_expected", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_owner", 32'(ldr_ack), 32'(e.who));
                        if (cpu_ack) chk("cpu_err", 32'(cpu_err), 32'(e.err));
                        chk("cpu_rdata", cpu_rdata, e.rdata);
                        chk("strobe_cycles", mon_en, e.en_cycles);
                    end
                    mon_en   = 0;
                    chk_idle = 1'b1;
                end else if (chk_idle) begin
                    chk("busy_after_resp", 32'(busy), 0);
                    chk_idle = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_ldr_ack", 32'(ldr_ack), 0);
        chk("rst_cpu_err", 32'(cpu_err), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ram_enable", 32'(ram_enable), 0);
        chk("rst_ram_read", 32'(ram_read), 0);
        chk("rst_ram_write", 32'(ram_write), 0);
        chk("rst_ram_address", 32'(ram_address), 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // CPU write then read back.
        cpu_q.push_back(mk(GNT_CPU, 1'b1, 3, 32'hA5A5A5A5, 1));
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 3, 32'h0, 1));
        run_round();

        // Simultaneous requests: loader first after reset, then CPU.
        cpu_q.push_back(mk(GNT_CPU, 1'b1, 20, 32'h0000_1234, 1));
        ldr_q.push_back(mk(GNT_LDR, 1'b1, 10, 32'h1, 1));
        run_round();

        // CPU held across three loader writes: LDR, CPU, LDR, LDR.
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 20, 32'h0, 2));
        ldr_q.push_back(mk(GNT_LDR, 1'b1, 30, 32'h30, 1));
        ldr_q.push_back(mk(GNT_LDR, 1'b1, 31, 32'h31, 1));
        ldr_q.push_back(mk(GNT_LDR, 1'b1, 32, 32'h32, 1));
        run_round();

        // Timeout on a read: error, old read data kept.
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 3, 32'h0, 0));
        run_round();

        // Late done, top address, done coinciding with the timeout, address 0.
        cpu_q.push_back(mk(GNT_CPU, 1'b1, 511, 32'hFFFFFFFF, 6));
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 511, 32'h0, TO));
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 10, 32'h0, 1));
        cpu_q.push_back(mk(GNT_CPU, 1'b1, 0, 32'h5A5A_0F0F, 3));
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 0, 32'h0, 2));
        run_round();

        // A done pulse during ISSUE must not end the access.
        spur = 1'b1;
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 3, 32'h0, 2));
        run_round();
        spur = 1'b0;

        // Reset two cycles into WAIT.
        ignore_access = 1'b1;
        delay_q.push_back(0);
        cpu_addr = 9'd7;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_enable", 32'(ram_enable), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_enable", 32'(ram_enable), 0);
        chk("async_rst_read", 32'(ram_read), 0);
        chk("async_rst_write", 32'(ram_write), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_ack", 32'(cpu_ack), 0);
        cpu_req = 1'b0;
        m_last  = GNT_CPU;
        m_rdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("async_rst_rdata", cpu_rdata, 0);
        delay_q.delete();
        reset_n = 1'b1;
        ignore_access = 1'b0;
        @(posedge clk);
        #1;

        cpu_q.push_back(mk(GNT_CPU, 1'b0, 3, 32'h0, 1));
        run_round();
        cpu_q.push_back(mk(GNT_CPU, 1'b0, 31, 32'h0, 1));
        ldr_q.push_back(mk(GNT_LDR, 1'b1, 40, 32'h40, 2));
        run_round();

        for (int r = 0; r < 40; r++) begin
            int nc = int'($urandom_range(0, 3));
            int nl = int'($urandom_range(0, 3));
            if (nc == 0 && nl == 0) nc = 1;
            for (int k = 0; k < nc; k++) begin
                cpu_q.push_back(mk(GNT_CPU, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                                   rnd_delay()));
            end
            for (int k = 0; k < nl; k++) begin
                ldr_q.push_back(mk(GNT_LDR, 1'b1, rnd_addr(), $urandom, rnd_delay()));
            end
            run_round();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
